pdes_sched: RTL and testbench

Parametrised event scheduler for the PHOLD/PDES engine. It sits between the shared priority event queue and NUM_CORE processing cores. It seeds the queue with initial events, accepts new events from the cores and dispatches the earliest event to a free core, both under round-robin arbitration. It maintains GVT and ends the run at a configurable end time, or when the simulation drains with no events left.

---
 rtl/pdes_sched.sv | 266 ++++++++++++++++++++++++++
 tb/tb_pdes_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdes_sched.sv
// pdes_sched -- event scheduler for the PHOLD/PDES engine.
//
// Sits between a shared first-word-fall-through priority event queue and
// NUM_CORE processing cores. It seeds the queue with NUM_INIT events at the
// start of a run. It then moves new events from the cores into the queue and
// dispatches the queue head to a free core, using one round-robin arbiter per
// direction. It tracks GVT and ends the run when GVT passes SIM_END_TIME, or
// when nothing is left in flight.
//
// Event word layout: {lp[LP_WID-1:0], time[TIME_WID-1:0]}.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            pulse, begins a run from IDLE
//   gvt, done, busy  registered GVT, end-of-run pulse, not-IDLE flag
//   core_ready       per-core "can take an event"
//   core_evt_vld     one-hot dispatch strobe; evt_time/evt_lp broadcast
//   core_new_vld     per-core "holding a new event"; core_new_data packed
//   core_new_ack     one-hot accept strobe for core_new_data
//   core_done        per-core pulse, current event finished
//   q_enq/q_din      queue write
//   q_deq/q_dout     queue pop / head word
//   q_empty/q_full   queue status
//
// Optional feature macro: SCHED_STATS_EN. When it is defined, the module
// adds the 32-bit saturating run counters stat_sent and stat_rcvd.
//
// Handshakes: every transfer is single-cycle and combinational. A strobe
// (q_enq, q_deq, core_evt_vld[i], core_new_ack[i]) is only raised when the
// other side's qualifier (!q_full, !q_empty, core_ready[i], core_new_vld[i])
// is high in that same cycle. The transfer completes at the next rising
// clock edge. A producer holds its data until the strobe is seen.

module pdes_sched #(
  parameter int NUM_CORE     = 8,
  parameter int TIME_WID     = 16,
  parameter int LP_WID       = 3,
  parameter int NUM_INIT     = 8,
  parameter int SIM_END_TIME = 4000,
  localparam int EVT_WID     = LP_WID + TIME_WID
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic [TIME_WID-1:0]         gvt,
  output logic                        done,
  output logic                        busy,
  input  logic [NUM_CORE-1:0]         core_ready,
  output logic [NUM_CORE-1:0]         core_evt_vld,
  output logic [TIME_WID-1:0]         evt_time,
  output logic [LP_WID-1:0]           evt_lp,
  input  logic [NUM_CORE-1:0]         core_new_vld,
  input  logic [NUM_CORE*EVT_WID-1:0] core_new_data,
  output logic [NUM_CORE-1:0]         core_new_ack,
  input  logic [NUM_CORE-1:0]         core_done,
  output logic                        q_enq,
  output logic [EVT_WID-1:0]          q_din,
  output logic                        q_deq,
  input  logic [EVT_WID-1:0]          q_dout,
  input  logic                        q_empty,
  input  logic                        q_full
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]                 stat_sent,
  output logic [31:0]                 stat_rcvd
`endif
);

  localparam int IDX_W = $clog2(NUM_CORE);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_INIT     = 2'd1,
    S_RUNNING  = 2'd2,
    S_FINISHED = 2'd3
  } state_t;

  state_t                state;
  logic [7:0]            seed_cnt;
  logic                  dispatched;
  logic [IDX_W-1:0]      rcv_ptr;
  logic [IDX_W-1:0]      snd_ptr;
  logic [NUM_CORE-1:0]   core_busy;
  logic [TIME_WID-1:0]   core_time [NUM_CORE];

  logic [TIME_WID-1:0]   q_time;
  logic [LP_WID-1:0]     q_lp;
  logic [EVT_WID-1:0]    new_evt [NUM_CORE];
  logic                  rcv_fire;
  logic                  dsp_fire;
  logic [IDX_W-1:0]      rcv_idx;
  logic [IDX_W-1:0]      snd_idx;
  logic [TIME_WID-1:0]   c_gvt;
  logic                  end_cond;

  assign q_time = q_dout[TIME_WID-1:0];
  assign q_lp   = q_dout[EVT_WID-1:TIME_WID];
  assign done   = (state == S_FINISHED);
  assign busy   = (state != S_IDLE);

  // Round-robin pick: among requesters choose the one with the smallest
  // upward distance from ptr (wrapping), so ptr itself has top priority.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CORE-1:0] req,
                                               input logic [IDX_W-1:0]    ptr);
    logic [IDX_W-1:0] pick;
    int               best_d;
    int               d;
    pick   = '0;
    best_d = NUM_CORE;
    for (int k = 0; k < NUM_CORE; k++) begin
      d = k - int'(ptr);
      if (d < 0) d = d + NUM_CORE;
      if (req[k] && (d < best_d)) begin
        best_d = d;
        pick   = IDX_W'(k);
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(NUM_CORE - 1)) ? '0 : g + IDX_W'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_CORE; k++) begin
      new_evt[k] = core_new_data[k*EVT_WID +: EVT_WID];
    end
  end

  // Receive wins the queue port. Dispatch still runs while the queue is full,
  // so cores can drain the queue and a full queue cannot deadlock.
  always_comb begin
    rcv_fire = (state == S_RUNNING) && (|core_new_vld) && !q_full;
    dsp_fire = (state == S_RUNNING) && !rcv_fire && !q_empty && (|core_ready);
    rcv_idx  = rr_pick(core_new_vld, rcv_ptr);
    snd_idx  = rr_pick(core_ready, snd_ptr);
  end

  always_comb begin
    q_enq        = 1'b0;
    q_din        = '0;
    q_deq        = 1'b0;
    core_new_ack = '0;
    core_evt_vld = '0;
    evt_time     = q_time;
    evt_lp       = q_lp;
    if (state == S_INIT) begin
      q_enq = !q_full;
      q_din = {LP_WID'(seed_cnt), {TIME_WID{1'b0}}};
    end else if (rcv_fire) begin
      q_enq        = 1'b1;
      q_din        = new_evt[rcv_idx];
      core_new_ack = NUM_CORE'(1) << rcv_idx;
    end else if (dsp_fire) begin
      q_deq        = 1'b1;
      core_evt_vld = NUM_CORE'(1) << snd_idx;
    end
  end

  // Candidate GVT: earliest time among busy cores and the queue head.
  // If neither a busy core nor a head exists, GVT holds.
  always_comb begin
    logic [TIME_WID-1:0] m;
    logic                have;
    m    = '1;
    have = 1'b0;
    for (int k = 0; k < NUM_CORE; k++) begin
      if (core_busy[k] && (core_time[k] <= m)) begin
        m    = core_time[k];
        have = 1'b1;
      end
    end
    if (!q_empty && (q_time <= m)) begin
      m    = q_time;
      have = 1'b1;
    end
    c_gvt = have ? m : gvt;
  end

  always_comb begin
    end_cond = (gvt > TIME_WID'(SIM_END_TIME)) ||
               (q_empty && !(|core_busy) && !(|core_new_vld) && dispatched);
  end

  // Main FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      seed_cnt   <= '0;
      dispatched <= 1'b0;
      gvt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_INIT;
            seed_cnt   <= '0;
            dispatched <= 1'b0;
            gvt        <= '0;
          end
        end
        S_INIT: begin
          if (q_enq) begin
            seed_cnt <= seed_cnt + 8'd1;
            if (seed_cnt == 8'(NUM_INIT - 1)) state <= S_RUNNING;
          end
        end
        S_RUNNING: begin
          gvt <= c_gvt;
          if (dsp_fire) dispatched <= 1'b1;
          if (end_cond) state <= S_FINISHED;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Arbiter pointers advance only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcv_ptr <= '0;
      snd_ptr <= '0;
    end else begin
      if (rcv_fire) rcv_ptr <= ptr_after(rcv_idx);
      if (dsp_fire) snd_ptr <= ptr_after(snd_idx);
    end
  end

  // Per-core tracking. A dispatch in the same cycle as core_done overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_busy <= '0;
      for (int k = 0; k < NUM_CORE; k++) core_time[k] <= '0;
    end else if (state == S_FINISHED) begin
      core_busy <= '0;
    end else begin
      for (int k = 0; k < NUM_CORE; k++) begin
        if (dsp_fire && (snd_idx == IDX_W'(k))) begin
          core_busy[k] <= 1'b1;
          core_time[k] <= q_time;
        end else if (core_done[k]) begin
          core_busy[k] <= 1'b0;
        end
      end
    end
  end

`ifdef SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_sent <= '0;
      stat_rcvd <= '0;
    end else if ((state == S_IDLE) && start) begin
      stat_sent <= '0;
      stat_rcvd <= '0;
    end else begin
      if (dsp_fire && (stat_sent != '1)) stat_sent <= stat_sent + 32'd1;
      if (rcv_fire && (stat_rcvd != '1)) stat_rcvd <= stat_rcvd + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pdes_sched.sv
// Directed testbench for pdes_sched (default parameters: 8 cores, 16-bit
// time, 3-bit LP, 8 seeds, end time 4000). The queue side is driven directly
// with hand-chosen head/empty/full values. Inputs change 1 ns after a rising
// edge, and outputs are checked before the next rising edge.

module tb_pdes_sched;

  localparam int NC = 8;
  localparam int TW = 16;
  localparam int LW = 3;
  localparam int EW = LW + TW;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [TW-1:0]     gvt;
  logic              done;
  logic              busy;
  logic [NC-1:0]     core_ready;
  logic [NC-1:0]     core_evt_vld;
  logic [TW-1:0]     evt_time;
  logic [LW-1:0]     evt_lp;
  logic [NC-1:0]     core_new_vld;
  logic [NC*EW-1:0]  core_new_data;
  logic [NC-1:0]     core_new_ack;
  logic [NC-1:0]     core_done;
  logic              q_enq;
  logic [EW-1:0]     q_din;
  logic              q_deq;
  logic [EW-1:0]     q_dout;
  logic              q_empty;
  logic              q_full;
`ifdef SCHED_STATS_EN
  logic [31:0]       stat_sent;
  logic [31:0]       stat_rcvd;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pdes_sched #(
    .NUM_CORE(NC), .TIME_WID(TW), .LP_WID(LW), .NUM_INIT(8), .SIM_END_TIME(4000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gvt(gvt), .done(done), .busy(busy),
    .core_ready(core_ready), .core_evt_vld(core_evt_vld), .evt_time(evt_time),
    .evt_lp(evt_lp), .core_new_vld(core_new_vld), .core_new_data(core_new_data),
    .core_new_ack(core_new_ack), .core_done(core_done), .q_enq(q_enq),
    .q_din(q_din), .q_deq(q_deq), .q_dout(q_dout), .q_empty(q_empty),
    .q_full(q_full)
`ifdef SCHED_STATS_EN
    , .stat_sent(stat_sent), .stat_rcvd(stat_rcvd)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] evt(input int lp, input int t);
    return {LW'(lp), TW'(t)};
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Writes all 8 seeds with the queue never full.
  task automatic seed_all(input string tag);
    for (int k = 0; k < 8; k++) begin
      #1;
      check({tag, "_enq"}, 64'(q_enq), 64'(1));
      check({tag, "_din"}, 64'(q_din), 64'(evt(k, 0)));
      tick();
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    core_ready   = '0;
    core_new_vld = '0;
    core_done    = '0;
    q_dout       = '0;
    q_empty      = 1'b1;
    q_full       = 1'b0;
    for (int i = 0; i < NC; i++) core_new_data[i*EW +: EW] = evt(i, 100 + i);

    // Reset state
    #12;
    check("rst_gvt", 64'(gvt), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_enq", 64'(q_enq), 64'(0));
    check("rst_deq", 64'(q_deq), 64'(0));
    check("rst_evt_vld", 64'(core_evt_vld), 64'(0));
    check("rst_ack", 64'(core_new_ack), 64'(0));
    rst_n = 1'b1;
    tick();

    // ---- Run 1: seeding ----
    do_start();
    check("init_busy", 64'(busy), 64'(1));
    seed_all("seed1");
    #1;
    check("run_no_enq", 64'(q_enq), 64'(0));

    // Receive priority and fairness: all cores offer, queue nonempty, all ready
    core_new_vld = '1;
    core_ready   = '1;
    q_empty      = 1'b0;
    q_dout       = evt(1, 50);
    for (int i = 0; i < 9; i++) begin
      #1;
      check("rcv_ack", 64'(core_new_ack), 64'(8'd1 << (i % 8)));
      check("rcv_din", 64'(q_din), 64'(evt(i % 8, 100 + (i % 8))));
      check("rcv_no_deq", 64'(q_deq), 64'(0));
      check("rcv_no_evt", 64'(core_evt_vld), 64'(0));
      tick();
    end
    check("rcv_gvt_head", 64'(gvt), 64'(50));

    // Dispatch: head {5,37}, cores 2 and 5 ready
    core_new_vld = '0;
    core_ready   = 8'b0010_0100;
    q_dout       = evt(5, 37);
    #1;
    check("dsp_vld", 64'(core_evt_vld), 64'(8'b0000_0100));
    check("dsp_time", 64'(evt_time), 64'(37));
    check("dsp_lp", 64'(evt_lp), 64'(5));
    check("dsp_deq", 64'(q_deq), 64'(1));
    tick();
    #1;
    check("dsp_next_vld", 64'(core_evt_vld), 64'(8'b0010_0000));
    tick();
    core_ready = '0;
    core_done  = 8'b0010_0100;
    tick();
    core_done  = '0;

    // GVT: core 1 busy at 120, core 3 busy at 90, head 100
    core_ready = 8'b0000_0010;
    q_dout     = evt(0, 120);
    #1;
    check("gvt_dsp1", 64'(core_evt_vld), 64'(8'b0000_0010));
    tick();
    core_ready = 8'b0000_1000;
    q_dout     = evt(0, 90);
    #1;
    check("gvt_dsp3", 64'(core_evt_vld), 64'(8'b0000_1000));
    tick();
    core_ready = '0;
    q_dout     = evt(0, 100);
    tick();
    check("gvt_min", 64'(gvt), 64'(90));
    core_done = 8'b0000_1000;
    tick();
    core_done = '0;
    check("gvt_lag", 64'(gvt), 64'(90));
    tick();
    check("gvt_after_done", 64'(gvt), 64'(100));

    // End by time: retire core 1, head at 4001
    core_done = 8'b0000_0010;
    q_dout    = evt(0, 4001);
    tick();
    core_done = '0;
    tick();
    check("end_gvt", 64'(gvt), 64'(4001));
    check("end_done_low", 64'(done), 64'(0));
    tick();
    check("end_done", 64'(done), 64'(1));
    check("end_busy_fin", 64'(busy), 64'(1));
    tick();
    check("end_done_pulse", 64'(done), 64'(0));
    check("end_busy_idle", 64'(busy), 64'(0));
    check("end_gvt_hold", 64'(gvt), 64'(4001));

    // ---- Run 2: seeding with a full-queue stall, then drain ----
    do_start();
    check("run2_gvt_clr", 64'(gvt), 64'(0));
    for (int k = 0; k < 3; k++) begin
      #1;
      check("seed2_din", 64'(q_din), 64'(evt(k, 0)));
      tick();
    end
    q_full = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("seed2_hold_enq", 64'(q_enq), 64'(0));
      check("seed2_hold_din", 64'(q_din), 64'(evt(3, 0)));
      tick();
    end
    q_full = 1'b0;
    for (int k = 3; k < 8; k++) begin
      #1;
      check("seed2_din", 64'(q_din), 64'(evt(k, 0)));
      tick();
    end
    check("seed2_busy", 64'(busy), 64'(1));
    q_empty    = 1'b0;
    q_dout     = evt(2, 10);
    core_ready = 8'b1000_0000;
    #1;
    check("drain_dsp", 64'(core_evt_vld), 64'(8'b1000_0000));
    tick();
    q_empty    = 1'b1;
    core_ready = '0;
    core_done  = 8'b1000_0000;
    tick();
    core_done  = '0;
    check("drain_not_yet", 64'(done), 64'(0));
    tick();
    check("drain_done", 64'(done), 64'(1));
    tick();
    check("drain_done_pulse", 64'(done), 64'(0));
    check("drain_busy", 64'(busy), 64'(0));
    check("drain_gvt", 64'(gvt), 64'(10));

    // ---- Run 3: full queue, then asynchronous reset mid-run ----
    do_start();
    seed_all("seed3");
    q_full       = 1'b1;
    q_empty      = 1'b0;
    q_dout       = evt(3, 200);
    core_new_vld = 8'b0000_0100;
    core_ready   = 8'b0000_0001;
    #1;
    check("full_no_ack", 64'(core_new_ack), 64'(0));
    check("full_no_enq", 64'(q_enq), 64'(0));
    check("full_deq", 64'(q_deq), 64'(1));
    check("full_dsp", 64'(core_evt_vld), 64'(8'b0000_0001));
    tick();
    check("full_gvt", 64'(gvt), 64'(200));
    core_ready = '0;
    q_full     = 1'b0;
    #1;
    check("unfull_ack", 64'(core_new_ack), 64'(8'b0000_0100));
    check("unfull_no_deq", 64'(q_deq), 64'(0));
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_gvt", 64'(gvt), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_ack", 64'(core_new_ack), 64'(0));
    check("arst_enq", 64'(q_enq), 64'(0));
    check("arst_deq", 64'(q_deq), 64'(0));
    check("arst_evt_vld", 64'(core_evt_vld), 64'(0));
    #10;
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_idle", 64'(busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
